iq_stream_fifo: RTL and testbench

Upstream feeder of the packetizer. Accepts one complex baseband sample per iq_valid strobe from the DDC, packs I/Q into 32-bit words, and buffers them in an on-chip FIFO. Presents the show-ahead read interface (rd_en/rd_data/rd_dr) and the a_full/a_empty level flags the packetizer consumes. Adds stream enable, flush and frame-safe overflow recovery.

---
 rtl/iq_stream_pkg.sv | 19 +
 rtl/iq_stream_ram.sv | 28 ++
 rtl/iq_stream_fifo.sv | 176 +++++++++++++++++
 tb/tb_iq_stream_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/iq_stream_pkg.sv
// Shared types and helpers for the I/Q stream FIFO: FSM states, word/sample widths, I/Q packing.
package iq_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int WORD_W   = 32;
  localparam int SAMPLE_W = 16;

  // I occupies the upper half so the packetizer sees I first on a big-endian wire.
  function automatic logic [WORD_W-1:0] pack_iq(input logic signed [SAMPLE_W-1:0] i_s,
                                                input logic signed [SAMPLE_W-1:0] q_s);
    return {i_s, q_s};
  endfunction

endpackage

// File: rtl/iq_stream_ram.sv
// Simple dual-port word store, one write port and one registered read port (read-first on collision).
// Latency: read data appears one clock after the address; no flow control, caller owns occupancy.
module iq_stream_ram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/iq_stream_fifo.sv
// Packs DDC I/Q samples into 32-bit words and buffers them for the packetizer; show-ahead read, 1-cycle write-to-visible, overflow drops until level recovers.
// Build option IQ_STREAM_TESTPAT_EN replaces sample data with a {cnt, ~cnt} counting pattern.
module iq_stream_fifo
  import iq_stream_pkg::*;
#(
  parameter int DEPTH_LOG2    = 12,
  parameter int IQ_WIDTH      = 16,
  parameter int AFULL_THRESH  = 3072,
  parameter int AEMPTY_THRESH = 16,
  parameter int RESUME_LEVEL  = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       iq_valid,
  input  logic signed [IQ_WIDTH-1:0] i_data,
  input  logic signed [IQ_WIDTH-1:0] q_data,
  input  logic                       rd_en,
  output logic [WORD_W-1:0]          rd_data,
  output logic                       rd_dr,
  output logic                       a_full,
  output logic                       a_empty,
  output logic [DEPTH_LOG2:0]        level,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(1 << DEPTH_LOG2);

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_raddr;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [WORD_W-1:0]       head_q, head_d, wr_dat, ram_rdata, byp_dat_q;
  logic                    byp_vld_q, byp_vld_d;
  logic                    a_full_q, a_empty_q, ovf_q, ovf_d;
  logic [15:0]             drop_q, drop_d;
  logic                    push, pop, drop, is_full;

`ifdef IQ_STREAM_TESTPAT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        unused_iq;

  assign unused_iq = ^{i_data, q_data};
  assign cnt_d     = flush ? 16'd0 : cnt_q + 16'(push);
  assign wr_dat    = {cnt_q, ~cnt_q};

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end
`else
  logic signed [SAMPLE_W-1:0] i_ext, q_ext;

  assign i_ext  = SAMPLE_W'(i_data);
  assign q_ext  = SAMPLE_W'(q_data);
  assign wr_dat = pack_iq(i_ext, q_ext);
`endif

  assign is_full = (level_q == DEPTH_L);
  assign pop     = rd_en && (level_q != '0) && !flush;

  // FSM outputs: a full FIFO still accepts a sample when the head is popped in the same cycle.
  always_comb begin
    push = 1'b0;
    drop = 1'b0;
    if (!flush && en && iq_valid) begin
      case (state_q)
        IDLE, RUN: begin
          if (is_full && !pop) drop = 1'b1;
          else                 push = 1'b1;
        end
        DROP:    drop = 1'b1;
        default: drop = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = en ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en) state_d = drop ? DROP : RUN;
        RUN:     if (!en) state_d = IDLE; else if (drop) state_d = DROP;
        DROP:    if (!en) state_d = IDLE;
                 else if (level_q <= LVL_W'(RESUME_LEVEL)) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    level_d  = flush ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
    ovf_d    = flush ? 1'b0 : (ovf_q | drop);
    drop_d   = drop_q;
    if (flush)                          drop_d = 16'd0;
    else if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  // The RAM always prefetches the word behind the next head; a same-edge write to
  // that slot is caught by the bypass register since the RAM reads old contents.
  assign ram_raddr = rd_ptr_d + DEPTH_LOG2'(1);
  assign byp_vld_d = push && (wr_ptr_q == ram_raddr);

  always_comb begin
    head_d = head_q;
    if (flush) begin
      head_d = '0;
    end else if (pop) begin
      if (level_q == LVL_W'(1)) begin
        if (push) head_d = wr_dat;
      end else begin
        head_d = byp_vld_q ? byp_dat_q : ram_rdata;
      end
    end else if (push && level_q == '0) begin
      head_d = wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      head_q    <= '0;
      byp_vld_q <= 1'b0;
      byp_dat_q <= '0;
      a_full_q  <= 1'b0;
      a_empty_q <= 1'b1;
      ovf_q     <= 1'b0;
      drop_q    <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      head_q    <= head_d;
      byp_vld_q <= byp_vld_d;
      byp_dat_q <= wr_dat;
      a_full_q  <= (level_d >= LVL_W'(AFULL_THRESH));
      a_empty_q <= (level_d <= LVL_W'(AEMPTY_THRESH));
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  iq_stream_ram #(
    .AW (DEPTH_LOG2),
    .DW (WORD_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_dat),
    .rd_addr_i (ram_raddr),
    .rd_data_o (ram_rdata)
  );

  assign rd_data  = head_q;
  assign rd_dr    = (level_q != '0);
  assign a_full   = a_full_q;
  assign a_empty  = a_empty_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_iq_stream_fifo.sv
// Scoreboard bench for iq_stream_fifo: stimulus queues expected words, a negedge monitor checks every pop.
module tb_iq_stream_fifo;

`ifdef IQ_STREAM_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, flush, iq_valid, rd_en;
  logic signed [15:0] i_data, q_data;
  logic [31:0]        rd_data;
  logic               rd_dr, a_full, a_empty, overflow;
  logic [12:0]        level;
  logic [15:0]        drop_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic [15:0] tb_cnt;
  logic [31:0] exp_t1 [3];

  iq_stream_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .iq_valid (iq_valid),
    .i_data   (i_data),
    .q_data   (q_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_dr    (rd_dr),
    .a_full   (a_full),
    .a_empty  (a_empty),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  function automatic logic [31:0] exp_word(input logic signed [15:0] i, input logic signed [15:0] q,
                                           input logic [15:0] c);
    return TP ? {c, ~c} : {i, q};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, record the expected word if the sample should be stored.
  task automatic cyc(input logic v, input logic signed [15:0] i, input logic signed [15:0] q,
                     input logic rd, input logic fl, input logic acc);
    iq_valid = v;
    i_data   = i;
    q_data   = q;
    rd_en    = rd;
    flush    = fl;
    if (fl) begin
      sb.delete();
      tb_cnt = 16'd0;
    end
    if (acc) begin
      sb.push_back(exp_word(i, q, tb_cnt));
      tb_cnt = tb_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    iq_valid = 1'b0;
    rd_en    = 1'b0;
    flush    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && rd_en && rd_dr) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: popped 0x%08h with nothing expected", rd_data);
      end else begin
        chk("sb_data", rd_data, sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; iq_valid = 1'b0; rd_en = 1'b0;
    i_data = '0; q_data = '0; tb_cnt = 16'd0;
    if (TP) begin
      exp_t1[0] = 32'h0000FFFF; exp_t1[1] = 32'h0001FFFE; exp_t1[2] = 32'h0002FFFD;
    end else begin
      exp_t1[0] = 32'h0001FFFF; exp_t1[1] = 32'h0002FFFE; exp_t1[2] = 32'h0003FFFD;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rd_dr", 32'(rd_dr), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_a_full", 32'(a_full), 32'd0);
    chk("rst_a_empty", 32'(a_empty), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Three samples, first visible one cycle after its strobe, then drain.
    en = 1'b1;
    cyc(1'b1, 16'sd1, -16'sd1, 1'b0, 1'b0, 1'b1);
    chk("t1_rd_dr_first", 32'(rd_dr), 32'd1);
    chk("t1_level_first", 32'(level), 32'd1);
    cyc(1'b1, 16'sd2, -16'sd2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'sd3, -16'sd3, 1'b0, 1'b0, 1'b1);
    chk("t1_level", 32'(level), 32'd3);
    chk("t1_a_empty", 32'(a_empty), 32'd1);
    chk("t1_head", rd_data, exp_t1[0]);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0);
      if (j < 2) chk("t1_next_head", rd_data, exp_t1[j+1]);
    end
    chk("t1_drained_level", 32'(level), 32'd0);
    chk("t1_drained_rd_dr", 32'(rd_dr), 32'd0);

    // Push and pop every cycle: level holds at one with no bubbles.
    cyc(1'b1, 16'sd100, -16'sd100, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 16'(101 + k), 16'(-(101 + k)), 1'b1, 1'b0, 1'b1);
      chk("t2_level", 32'(level), 32'd1);
      chk("t2_rd_dr", 32'(rd_dr), 32'd1);
    end
    cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0);
    chk("t2_level_end", 32'(level), 32'd0);
    chk("t2_drop_cnt", 32'(drop_cnt), 32'd0);

    // Fill to full, overflow by five, recover at the resume level.
    for (int k = 1; k <= 4096; k++) begin
      cyc(1'b1, 16'(k), 16'(-k), 1'b0, 1'b0, 1'b1);
      if (k == 16 || k == 17)     chk("t3_a_empty_edge", 32'(a_empty), (k == 16) ? 32'd1 : 32'd0);
      if (k == 3071 || k == 3072) chk("t3_a_full_edge", 32'(a_full), (k == 3072) ? 32'd1 : 32'd0);
    end
    chk("t3_level_full", 32'(level), 32'd4096);
    for (int k = 0; k < 5; k++) cyc(1'b1, 16'sd9, -16'sd9, 1'b0, 1'b0, 1'b0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd5);
    chk("t3_level_after_drop", 32'(level), 32'd4096);
    for (int k = 0; k < 2048; k++) cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0);
    chk("t3_level_resume", 32'(level), 32'd2048);
    chk("t3_a_full_low", 32'(a_full), 32'd0);
    cyc(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'sd7, -16'sd7, 1'b0, 1'b0, 1'b1);
    chk("t3_accept_after_resume", 32'(level), 32'd2049);
    chk("t3_drop_cnt_hold", 32'(drop_cnt), 32'd5);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Flush clears sticky status, then flush beats a same-cycle write and read.
    cyc(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0);
    chk("t4_flush_overflow", 32'(overflow), 32'd0);
    chk("t4_flush_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t4_flush_level", 32'(level), 32'd0);
    for (int k = 0; k < 100; k++) cyc(1'b1, 16'(k), 16'(k), 1'b0, 1'b0, 1'b1);
    chk("t4_level_100", 32'(level), 32'd100);
    cyc(1'b1, 16'sd5, -16'sd5, 1'b1, 1'b1, 1'b0);
    chk("t4_level_zero", 32'(level), 32'd0);
    chk("t4_rd_dr", 32'(rd_dr), 32'd0);
    chk("t4_a_empty", 32'(a_empty), 32'd1);
    cyc(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0);
    chk("t4_no_write", 32'(level), 32'd0);

    // Disabled stream ignores strobes without counting drops; empty reads do nothing.
    for (int k = 0; k < 5; k++) cyc(1'b1, 16'(-300 - k), 16'(300 + k), 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 16'sd1, 16'sd1, 1'b0, 1'b0, 1'b0);
    chk("t5_en0_level", 32'(level), 32'd5);
    chk("t5_en0_drop_cnt", 32'(drop_cnt), 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0);
    chk("t5_empty_rd_level", 32'(level), 32'd0);
    chk("t5_empty_rd_dr", 32'(rd_dr), 32'd0);
    chk("t5_empty_a_empty", 32'(a_empty), 32'd1);

    // Reset mid-stream discards buffered words.
    en = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b1, 16'sd44, 16'sd55, 1'b0, 1'b0, 1'b1);
    chk("t6_level_pre", 32'(level), 32'd3);
    rst = 1'b1;
    sb.delete();
    tb_cnt = 16'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_rd_dr", 32'(rd_dr), 32'd0);
    chk("t6_rst_rd_data", rd_data, 32'd0);
    chk("t6_rst_a_empty", 32'(a_empty), 32'd1);
    chk("sb_left_over", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
